adder_arbiter: RTL and testbench

//  Shares one 16-bit adder/flag unit among NREQ requesters via round-robin arbitration.
//  - Each requester presents operands a,b with a valid/ready handshake.
//  - The winner's sum and flags (sn, ZR, CY, P, V) are registered and returned on a single

---
 rtl/adder_arbiter_pkg.sv | 22 ++
 rtl/adder_arbiter_if.sv | 27 ++
 rtl/adder_arbiter_adder16_flags.sv | 31 +++
 rtl/adder_arbiter.sv | 162 ++++++++++++++++
 tb/tb_adder_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arbiter_pkg.sv
// Shared encodings for the adder arbiter: FSM state values and response flag bit positions.
// Used by adder_arbiter (ADD_ARB_STATS_EN optional) and adder16_flags.
package add_arb_pkg;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COMPUTE = 2'd1;
   localparam logic [1:0] HOLD    = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = IDLE,
      ST_COMPUTE = COMPUTE,
      ST_HOLD    = HOLD
   } arb_state_e;

   localparam int FLG_W  = 5;
   localparam int FLG_SN = 4;
   localparam int FLG_ZR = 3;
   localparam int FLG_CY = 2;
   localparam int FLG_P  = 1;
   localparam int FLG_V  = 0;

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bundle between client blocks (master) and the adder arbiter (slave).
interface adder_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 16
) ();
   localparam int ID_W = $clog2(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [ID_W-1:0]   rsp_id;
   logic [W-1:0]      rsp_sum;
   logic [4:0]        rsp_flags;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_flags
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_flags
   );
endinterface

// File: rtl/adder_arbiter_adder16_flags.sv
// Combinational W-bit adder producing the sum and the {sn,ZR,CY,P,V} flag vector.
module adder16_flags
   import add_arb_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   output logic [W-1:0]     sum,
   output logic [FLG_W-1:0] flags
);

   logic [W:0] full_s;

   function automatic logic even_parity(input logic [W-1:0] v);
      return ~^v;
   endfunction

   // Sum with carry and derived flags; V is signed overflow of a two's-complement add.
   always_comb begin
      full_s         = {1'b0, a} + {1'b0, b};
      sum            = full_s[W-1:0];
      flags          = '0;
      flags[FLG_SN]  = full_s[W-1];
      flags[FLG_ZR]  = (full_s[W-1:0] == '0);
      flags[FLG_CY]  = full_s[W];
      flags[FLG_P]   = even_parity(full_s[W-1:0]);
      flags[FLG_V]   = (a[W-1] == b[W-1]) && (full_s[W-1] != a[W-1]);
   end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder among NREQ requesters; one response in flight at a time.
// Optional per-requester grant counters when ADD_ARB_STATS_EN is defined.
module adder_arbiter
   import add_arb_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int W      = 16
`ifdef ADD_ARB_STATS_EN
   ,
   parameter int STAT_W = 16
`endif
) (
   input  logic                    clk,
   input  logic                    rst,
   adder_arbiter_if.slave          bus,
   output logic                    busy
`ifdef ADD_ARB_STATS_EN
   ,
   output logic [NREQ*STAT_W-1:0]  grant_cnt
`endif
);

   localparam int ID_W = $clog2(NREQ);

   arb_state_e       state_q, state_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [W-1:0]     rsp_sum_q, rsp_sum_d;
   logic [FLG_W-1:0] rsp_flags_q, rsp_flags_d;
   logic [NREQ-1:0]  req_ready_s;
   logic [ID_W:0]    pick_s;
   logic [W-1:0]     sum_s;
   logic [FLG_W-1:0] flags_s;

   // Returns {found, index} of the first valid requester at or after ptr, wrapping.
   function automatic logic [ID_W:0] pick(input logic [NREQ-1:0] valid, input logic [ID_W-1:0] ptr);
      logic [ID_W:0] res;
      int            idx;
      res = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NREQ;
         res = valid[idx] ? {1'b1, idx[ID_W-1:0]} : res;
      end
      return res;
   endfunction

   assign pick_s = pick(bus.req_valid, ptr_q);

   adder16_flags #(.W(W)) u_adder (
      .a     (a_q),
      .b     (b_q),
      .sum   (sum_s),
      .flags (flags_s)
   );

   // Next-state and next-register values for the arbitration FSM.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      a_d         = a_q;
      b_d         = b_q;
      rsp_valid_d = rsp_valid_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_flags_d = rsp_flags_q;
      req_ready_s = '0;
      case (state_q)
         ST_IDLE: begin
            if (pick_s[ID_W]) begin
               req_ready_s[pick_s[ID_W-1:0]] = 1'b1;
               id_d    = pick_s[ID_W-1:0];
               a_d     = bus.req_a[int'(pick_s[ID_W-1:0])*W +: W];
               b_d     = bus.req_b[int'(pick_s[ID_W-1:0])*W +: W];
               state_d = ST_COMPUTE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_COMPUTE: begin
            rsp_sum_d   = sum_s;
            rsp_flags_d = flags_s;
            rsp_valid_d = 1'b1;
            state_d     = ST_HOLD;
         end
         ST_HOLD: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               // The pointer moves only once the response drains, so the next winner follows the served id.
               ptr_d       = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + ID_W'(1);
               state_d     = ST_IDLE;
            end else begin
               state_d     = ST_HOLD;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // FSM and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         rsp_valid_q <= 1'b0;
         rsp_sum_q   <= '0;
         rsp_flags_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         a_q         <= a_d;
         b_q         <= b_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_flags_q <= rsp_flags_d;
      end
   end

   assign bus.req_ready = req_ready_s;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = id_q;
   assign bus.rsp_sum   = rsp_sum_q;
   assign bus.rsp_flags = rsp_flags_q;
   assign busy          = (state_q != ST_IDLE);

`ifdef ADD_ARB_STATS_EN
   logic [NREQ*STAT_W-1:0] cnt_q, cnt_d;

   // Saturating grant counters, one per requester.
   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < NREQ; i++) begin
         if (bus.req_valid[i] && req_ready_s[i] && (cnt_q[i*STAT_W +: STAT_W] != {STAT_W{1'b1}})) begin
            cnt_d[i*STAT_W +: STAT_W] = cnt_q[i*STAT_W +: STAT_W] + STAT_W'(1);
         end else begin
            cnt_d[i*STAT_W +: STAT_W] = cnt_q[i*STAT_W +: STAT_W];
         end
      end
   end

   // Grant counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: vector table plus multi-cycle sequences, scoreboard on responses.
module tb_adder_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 16;

   typedef struct {
      int          id;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] sum;
      logic [4:0]  flags;
   } vec_t;

   typedef struct {
      int          id;
      logic [15:0] sum;
      logic [4:0]  flags;
      int          t;
   } sb_t;

   logic clk = 1'b0;
   logic rst;
   logic busy;
`ifdef ADD_ARB_STATS_EN
   logic [NREQ*16-1:0] grant_cnt;
`endif

   adder_arbiter_if #(.NREQ(NREQ), .W(W)) bus_if ();

   adder_arbiter #(.NREQ(NREQ), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_if),
      .busy      (busy)
`ifdef ADD_ARB_STATS_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc   = 0;
   logic        prev_valid = 1'b0;
   vec_t        vecs [8];
   logic [15:0] exp_sum [NREQ];
   logic [4:0]  exp_flg [NREQ];
   sb_t         sb_q [$];
   int          grant_log [$];
   int          grant_cyc [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: record grants/expectations on accept, compare on response handshake.
   always @(negedge clk) begin
      sb_t e;
      if (rst) begin
         sb_q.delete();
         prev_valid <= 1'b0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (bus_if.req_valid[i] && bus_if.req_ready[i]) begin
               e.id = i; e.sum = exp_sum[i]; e.flags = exp_flg[i]; e.t = cyc;
               sb_q.push_back(e);
               grant_log.push_back(i);
               grant_cyc.push_back(cyc);
            end
         end
         if (bus_if.rsp_valid && !prev_valid && sb_q.size() > 0)
            check("latency", cyc - sb_q[0].t, 2);
         if (bus_if.rsp_valid && bus_if.rsp_ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_rsp", 1, 0);
            end else begin
               e = sb_q.pop_front();
               check("rsp_id", bus_if.rsp_id, e.id);
               check("rsp_sum", bus_if.rsp_sum, e.sum);
               check("rsp_flags", bus_if.rsp_flags, e.flags);
            end
         end
         prev_valid <= bus_if.rsp_valid;
      end
   end

   task automatic set_req(input vec_t v);
      exp_sum[v.id] = v.sum;
      exp_flg[v.id] = v.flags;
      bus_if.req_a[v.id*16 +: 16] = v.a;
      bus_if.req_b[v.id*16 +: 16] = v.b;
   endtask

   task automatic send(input vec_t v);
      int k;
      @(posedge clk); #1;
      set_req(v);
      bus_if.req_valid[v.id] = 1'b1;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus_if.req_ready[v.id]) break;
      end
      if (k == 20) check("accept_timeout", 0, 1);
      @(posedge clk); #1;
      bus_if.req_valid[v.id] = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 30 && sb_q.size() != 0; k++) @(negedge clk);
      if (sb_q.size() != 0) check("drain_timeout", sb_q.size(), 0);
   endtask

   initial begin
      int k;
      vecs[0] = '{0, 16'h8fff, 16'h8000, 16'h0fff, 5'b00111};
      vecs[1] = '{1, 16'hfffe, 16'h0002, 16'h0000, 5'b01110};
      vecs[2] = '{2, 16'haaaa, 16'h5555, 16'hffff, 5'b10010};
      vecs[3] = '{3, 16'h7fff, 16'h0001, 16'h8000, 5'b10001};
      vecs[4] = '{0, 16'h0000, 16'h0000, 16'h0000, 5'b01010};
      vecs[5] = '{1, 16'h1234, 16'h4321, 16'h5555, 5'b00010};
      vecs[6] = '{2, 16'h8000, 16'h8000, 16'h0000, 5'b01111};
      vecs[7] = '{3, 16'hffff, 16'hffff, 16'hfffe, 5'b10100};

      rst = 1'b1;
      bus_if.req_valid = '0;
      bus_if.req_a     = '0;
      bus_if.req_b     = '0;
      bus_if.rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_rsp_valid", bus_if.rsp_valid, 0);
      check("rst_rsp_id", bus_if.rsp_id, 0);
      check("rst_rsp_sum", bus_if.rsp_sum, 0);
      check("rst_rsp_flags", bus_if.rsp_flags, 0);
      check("rst_req_ready", bus_if.req_ready, 0);
      check("rst_busy", busy, 0);

      // Table: one requester at a time.
      bus_if.rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send(vecs[i]);
         drain();
      end

      // All requesters valid continuously from a fresh pointer.
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      grant_log.delete();
      grant_cyc.delete();
      for (int i = 0; i < NREQ; i++) set_req(vecs[i]);
      bus_if.req_valid = 4'hf;
      for (k = 0; k < 40; k++) begin
         @(negedge clk);
         if (grant_log.size() >= 6) break;
      end
      @(posedge clk); #1 bus_if.req_valid = '0;
      drain();
      check("rr_grants", grant_log.size(), 6);
      for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
         check("rr_order", grant_log[i], i % NREQ);
         if (i > 0) check("rr_spacing", grant_cyc[i] - grant_cyc[i-1], 3);
      end
`ifdef ADD_ARB_STATS_EN
      check("cnt0", grant_cnt[15:0], 2);
      check("cnt1", grant_cnt[31:16], 2);
      check("cnt2", grant_cnt[47:32], 1);
      check("cnt3", grant_cnt[63:48], 1);
`endif

      // Back-pressure: response held for 5 cycles while requester 3 waits.
      bus_if.rsp_ready = 1'b0;
      send(vecs[2]);
      set_req(vecs[3]);
      bus_if.req_valid[3] = 1'b1;
      for (k = 0; k < 10; k++) begin
         if (bus_if.rsp_valid) break;
         @(negedge clk);
      end
      for (int j = 0; j < 5; j++) begin
         check("hold_valid", bus_if.rsp_valid, 1);
         check("hold_id", bus_if.rsp_id, 2);
         check("hold_sum", bus_if.rsp_sum, 16'hffff);
         check("hold_flags", bus_if.rsp_flags, 5'b10010);
         check("hold_req_ready", bus_if.req_ready, 0);
         check("hold_busy", busy, 1);
         @(posedge clk); #1;
      end
      bus_if.rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("release_valid", bus_if.rsp_valid, 0);
      check("release_busy", busy, 0);
      check("release_next_grant", bus_if.req_ready, 4'b1000);
      @(posedge clk); #1 bus_if.req_valid[3] = 1'b0;
      drain();

      // Reset during COMPUTE discards the transaction and clears the pointer.
      send(vecs[1]);
      drain();
      @(posedge clk); #1;
      set_req(vecs[2]);
      bus_if.req_valid[2] = 1'b1;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus_if.req_ready[2]) break;
      end
      @(posedge clk); #1;
      rst = 1'b1;
      bus_if.req_valid = '0;
      @(posedge clk); #1 rst = 1'b0;
      check("midrst_valid", bus_if.rsp_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_sum", bus_if.rsp_sum, 0);
`ifdef ADD_ARB_STATS_EN
      check("midrst_cnt", grant_cnt, 0);
`endif
      set_req(vecs[1]);
      set_req(vecs[3]);
      bus_if.req_valid = 4'b1010;
      #1 check("midrst_ptr", bus_if.req_ready, 4'b0010);
      @(posedge clk); #1 bus_if.req_valid[1] = 1'b0;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus_if.req_ready[3]) break;
      end
      @(posedge clk); #1 bus_if.req_valid[3] = 1'b0;
      drain();
      repeat (3) @(negedge clk);
      check("final_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
